// File: rtl/adder_pkg.sv
// Shared defaults for the adder family.
// Sibling adder blocks take their width from here.
package adder_pkg;

  localparam int ADDER_WIDTH = 16;

endpackage : adder_pkg

// File: rtl/full_adder.sv
// One-bit full adder cell.
// Purely combinational; chained to form the ripple adder.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic cin,
  output logic s,
  output logic cout
);

  logic p;

  assign p    = a ^ b;
  assign s    = p ^ cin;
  assign cout = (a & b) | (cin & p);

endmodule : full_adder

// File: rtl/ripple_carry_adder.sv
// Registered unsigned adder built from a ripple chain of full adders.
// Carry-out of the top bit lands in Cout one cycle after the operands.
module ripple_carry_adder
  import adder_pkg::*;
#(
  parameter int WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] operand1,
  input  logic [WIDTH-1:0] operand2,
  output logic             Cout,
  output logic [WIDTH-1:0] Result
);

  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] sum_d;
  logic [WIDTH-1:0] result_q;
  logic             cout_d;
  logic             cout_q;

  // No carry-in port: the chain starts from zero.
  assign c[0] = 1'b0;

  for (genvar i = 0; i < WIDTH; i++) begin : g_fa
    full_adder u_fa (
      .a    (operand1[i]),
      .b    (operand2[i]),
      .cin  (c[i]),
      .s    (sum_d[i]),
      .cout (c[i+1])
    );
  end

  assign cout_d = c[WIDTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      result_q <= '0;
      cout_q   <= 1'b0;
    end else begin
      result_q <= sum_d;
      cout_q   <= cout_d;
    end
  end

  assign Result = result_q;
  assign Cout   = cout_q;

endmodule : ripple_carry_adder

// File: tb/tb_ripple_carry_adder.sv
// Directed and random checks for the registered ripple adder.
// Vectors go in on the falling edge and are checked just after the rise.
module tb_ripple_carry_adder;

  localparam int W = 16;

  logic         clk;
  logic         rst;
  logic [W-1:0] operand1;
  logic [W-1:0] operand2;
  logic         Cout;
  logic [W-1:0] Result;

  int nvec;
  int nfail;

  typedef struct {
    logic         rst;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         cout;
    logic [W-1:0] res;
    string        name;
  } vec_t;

  vec_t tbl [12];

  ripple_carry_adder #(.WIDTH(W)) dut (
    .clk      (clk),
    .rst      (rst),
    .operand1 (operand1),
    .operand2 (operand2),
    .Cout     (Cout),
    .Result   (Result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic apply(
    input logic         r,
    input logic [W-1:0] a,
    input logic [W-1:0] b,
    input logic         ec,
    input logic [W-1:0] er,
    input string        name
  );
    @(negedge clk);
    rst      = r;
    operand1 = a;
    operand2 = b;
    @(posedge clk);
    #1;
    nvec++;
    if (Cout !== ec || Result !== er) begin
      nfail++;
      $display("FAIL %s: got Cout=%b Result=%h, want Cout=%b Result=%h",
               name, Cout, Result, ec, er);
    end
  endtask

  initial begin
    logic [W-1:0] ra;
    logic [W-1:0] rb;
    logic [W:0]   m;

    nvec     = 0;
    nfail    = 0;
    rst      = 1'b1;
    operand1 = 16'h1234;
    operand2 = 16'hFEDC;

    tbl[0]  = '{1'b1, 16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, "reset0"};
    tbl[1]  = '{1'b1, 16'h8001, 16'h8001, 1'b0, 16'h0000, "reset1"};
    tbl[2]  = '{1'b0, 16'hA0A0, 16'hA0A0, 1'b1, 16'h4140, "a0a0"};
    tbl[3]  = '{1'b0, 16'h58F4, 16'hF4F4, 1'b1, 16'h4DE8, "58f4"};
    tbl[4]  = '{1'b0, 16'h0F3D, 16'h0F0F, 1'b0, 16'h1E4C, "0f3d"};
    tbl[5]  = '{1'b0, 16'hC8CA, 16'hC8CA, 1'b1, 16'h9194, "c8ca"};
    tbl[6]  = '{1'b0, 16'hFFFF, 16'h0001, 1'b1, 16'h0000, "wrap"};
    tbl[7]  = '{1'b0, 16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFE, "maxmax"};
    tbl[8]  = '{1'b0, 16'h0000, 16'h0000, 1'b0, 16'h0000, "zero"};
    tbl[9]  = '{1'b0, 16'h0001, 16'h7FFF, 1'b0, 16'h8000, "ripple15"};
    tbl[10] = '{1'b0, 16'h5555, 16'hAAAA, 1'b0, 16'hFFFF, "noprop"};
    tbl[11] = '{1'b0, 16'h8000, 16'h8000, 1'b1, 16'h0000, "topcarry"};

    foreach (tbl[i])
      apply(tbl[i].rst, tbl[i].a, tbl[i].b,
            tbl[i].cout, tbl[i].res, tbl[i].name);

    // Hold: same inputs on consecutive edges keep the same outputs.
    apply(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, "hold0");
    apply(1'b0, 16'h1234, 16'h4321, 1'b0, 16'h5555, "hold1");

    // Reset mid-stream wins over live operands, then adds resume.
    apply(1'b0, 16'hF000, 16'h1001, 1'b1, 16'h0001, "pre_rst");
    apply(1'b1, 16'hF000, 16'h1001, 1'b0, 16'h0000, "mid_rst");
    apply(1'b0, 16'hF000, 16'h1001, 1'b1, 16'h0001, "post_rst");
    apply(1'b0, 16'h00FF, 16'h0001, 1'b0, 16'h0100, "post_rst2");

    for (int i = 0; i < 200; i++) begin
      ra = W'($urandom);
      rb = W'($urandom);
      m  = {1'b0, ra} + {1'b0, rb};
      apply(1'b0, ra, rb, m[W], m[W-1:0], "random");
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule : tb_ripple_carry_adder
